// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin RAM arbiter.
// Holds the arbitration state enum plus ID-width and ring-distance helpers.
package mem_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Distance from pointer p to requester i going upward around a ring of n.
  function automatic int rr_dist(input int i, input int p, input int n);
    return (i - p + n) % n;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester/RAM bus of the arbiter; slave is the arbiter, master is clients plus RAM.
// Handshake is valid/ready per requester, responses are valid-only (no backpressure).
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int DATA = 8,
  parameter int ADDR = 4,
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_we;
  logic [NREQ-1:0]      req_lock;
  logic [NREQ*ADDR-1:0] req_addr;
  logic [NREQ*DATA-1:0] req_wdata;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [DATA-1:0]      rsp_rdata;
  logic                 ram_we;
  logic [ADDR-1:0]      ram_addr;
  logic [DATA-1:0]      ram_wdata;
  logic [DATA-1:0]      ram_rdata;

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, ram_rdata,
    input  req_ready, rsp_valid, rsp_id, rsp_rdata, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, ram_rdata,
    output req_ready, rsp_valid, rsp_id, rsp_rdata, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin picker: nearest valid requester at or above ptr wins.
// Zero latency; produces one-hot grant plus encoded ID, all zero when nothing is valid.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id
);

  int best;

  always_comb begin
    best = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (valid[i] && rr_dist(i, int'(ptr), NREQ) < best) begin
        best = rr_dist(i, int'(ptr), NREQ);
      end
    end
    gnt = '0;
    id  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (valid[i] && rr_dist(i, int'(ptr), NREQ) == best) begin
        gnt[i] = 1'b1;
        id     = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sharing of one RAM: 0-cycle grant, 1-cycle tagged response, no response backpressure.
// MEM_ARB_LOCK_EN adds a LOCKED state that keeps the grant with one owner for atomic RMW.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA = 8,
  parameter int ADDR = 4,
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  owner;
  logic [IDW-1:0]  gnt_id;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic            xfer;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;

  always_comb begin
    elig = bus.req_valid;
`ifdef MEM_ARB_LOCK_EN
    for (int i = 0; i < NREQ; i++) begin
      if (state == LOCKED && IDW'(i) != owner) elig[i] = 1'b0;
    end
`endif
  end

  mem_arb_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .valid (elig),
    .ptr   (ptr),
    .gnt   (gnt),
    .id    (gnt_id)
  );

  assign bus.req_ready = reset ? '0 : gnt;
  assign xfer          = |bus.req_ready;

  always_comb begin
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_ready[i]) begin
        bus.ram_we    = bus.req_we[i];
        bus.ram_addr  = bus.req_addr[i*ADDR +: ADDR];
        bus.ram_wdata = bus.req_wdata[i*DATA +: DATA];
      end
    end
  end

`ifdef MEM_ARB_LOCK_EN
  logic xfer_lock;
  assign xfer_lock = |(bus.req_ready & bus.req_lock);
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus.req_lock, owner, state};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB;
      ptr         <= '0;
      owner       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= xfer;
      if (xfer) begin
        rsp_id_q <= gnt_id;
        // An owner transfer also moves ptr, so unlocking leaves ptr at owner+1.
        ptr      <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
`ifdef MEM_ARB_LOCK_EN
        if (state == ARB && xfer_lock) begin
          state <= LOCKED;
          owner <= gnt_id;
        end else if (state == LOCKED && !xfer_lock) begin
          state <= ARB;
        end
`endif
      end
    end
  end

  // A response already registered is dropped if reset arrives in its delivery cycle.
  assign bus.rsp_valid = rsp_valid_q & ~reset;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_rdata = bus.ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural RAM and reference model.
module tb_mem_arbiter;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA(8), .ADDR(4), .NREQ(NREQ), .IDW(2)) bus ();

  mem_arbiter #(.DATA(8), .ADDR(4), .NREQ(NREQ), .IDW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Single-port RAM with registered, read-before-write output.
  logic [7:0] ram [16] = '{default: 8'h00};
  always @(posedge clk) begin
    bus.ram_rdata <= ram[bus.ram_addr];
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model state.
  logic [7:0] m_mem [16] = '{default: 8'h00};
  int  m_ptr = 0;
  bit  m_locked = 0;
  int  m_owner = 0;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         due;
  } rsp_t;
  rsp_t exp_q [$];

  function automatic int model_pick(input logic rst, input logic [3:0] v);
    if (rst) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i = (m_ptr + k) % NREQ;
      if (v[i] && (!m_locked || i == m_owner)) return i;
    end
    return -1;
  endfunction

  task automatic step(input logic rst, input logic [3:0] v, input logic [3:0] we,
                      input logic [3:0] lk, input logic [15:0] a, input logic [31:0] wd,
                      output int g);
    logic [3:0] exp_rdy;
    logic [3:0] ea;
    logic [7:0] ed;
    reset         = rst;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_lock  = lk;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    #3;
    g = model_pick(rst, v);
    exp_rdy = '0;
    ea = '0;
    ed = '0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      ea = a[g*4 +: 4];
      ed = wd[g*8 +: 8];
    end
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("ram_we", 32'(bus.ram_we), (g >= 0) ? 32'(we[g]) : 32'd0);
    chk("ram_addr", 32'(bus.ram_addr), 32'(ea));
    chk("ram_wdata", 32'(bus.ram_wdata), 32'(ed));
    if (g >= 0) begin
      exp_q.push_back('{id: g, data: m_mem[ea], due: cyc + 1});
      if (we[g]) m_mem[ea] = ed;
      m_ptr = (g + 1) % NREQ;
`ifdef MEM_ARB_LOCK_EN
      if (!m_locked && lk[g]) begin
        m_locked = 1;
        m_owner  = g;
      end else if (m_locked && !lk[g]) begin
        m_locked = 0;
      end
`endif
    end
    if (rst) begin
      m_ptr    = 0;
      m_locked = 0;
      m_owner  = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Response monitor: independent of the driver, pops the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
      chk("rsp_valid_in_reset", 32'(bus.rsp_valid), 32'd0);
    end else if (bus.rsp_valid) begin
      if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
        chk("rsp_spurious", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.data));
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      void'(exp_q.pop_front());
      chk("rsp_missing", 32'd0, 32'd1);
    end
  end

  logic [3:0]  p_v, p_we, p_lk;
  logic [15:0] p_a;
  logic [31:0] p_wd;

  task automatic new_req(input int i);
    p_v[i]          = ($urandom_range(0, 3) != 0);
    p_we[i]         = 1'($urandom_range(0, 1));
    p_lk[i]         = ($urandom_range(0, 3) == 0);
    p_a[i*4 +: 4]   = 4'($urandom);
    p_wd[i*8 +: 8]  = 8'($urandom);
  endtask

  initial begin
    int g;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    @(posedge clk);
    cyc++;
    #1;

    // Reset with every requester valid: nothing is granted.
    step(1'b1, 4'b1111, 4'b1111, 4'b0000, 16'h1234, 32'h11223344, g);
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 16'h0000, 32'h0, g);

    // Fill all addresses so every later read has a known value.
    for (int a = 0; a < 16; a++) begin
      logic [3:0]  v1;
      logic [15:0] aa;
      logic [31:0] dd;
      v1 = '0;
      v1[a % 4] = 1'b1;
      aa = {4{4'(a)}};
      dd = {4{8'($urandom)}};
      step(1'b0, v1, 4'b1111, 4'b0000, aa, dd, g);
    end

    // Write then read the same address back to back.
    step(1'b0, 4'b0001, 4'b0001, 4'b0000, 16'h0003, 32'h000000A5, g);
    step(1'b0, 4'b0001, 4'b0000, 4'b0000, 16'h0003, 32'h0, g);

    // Fairness from ptr=0 with all four reading distinct addresses.
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 16'h0, 32'h0, g);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 4'b1111, 4'b0000, 4'b0000, 16'h7654 + 16'(k * 16'h1111), 32'h0, g);
      chk("fair_order", 32'(g), 32'(k % 4));
    end

    // Pointer skip: move ptr to 2, then only req1 and req3 valid.
    step(1'b0, 4'b0010, 4'b0000, 4'b0000, 16'h0090, 32'h0, g);
    step(1'b0, 4'b1010, 4'b0000, 4'b0000, 16'hB0A0, 32'h0, g);
    chk("skip_first", 32'(g), 32'd3);
    step(1'b0, 4'b0010, 4'b0000, 4'b0000, 16'h00A0, 32'h0, g);
    chk("skip_second", 32'(g), 32'd1);

    // Lock sequence: ptr=1, req1 takes lock on address 5 while req0/req2 wait.
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 16'h0, 32'h0, g);
    step(1'b0, 4'b0001, 4'b0000, 4'b0000, 16'h0002, 32'h0, g);
    step(1'b0, 4'b0111, 4'b0000, 4'b0010, 16'h0858, 32'h0, g);
    for (int k = 0; k < 3; k++) step(1'b0, 4'b0111, 4'b0000, 4'b0010, 16'h0858, 32'h0, g);
    step(1'b0, 4'b0111, 4'b0010, 4'b0000, 16'h0858, 32'h00003C00, g);
    step(1'b0, 4'b0101, 4'b0000, 4'b0000, 16'h0808, 32'h0, g);

    // Reset in the cycle after an accepted read.
    step(1'b0, 4'b0100, 4'b0000, 4'b0000, 16'h0700, 32'h0, g);
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 16'h0000, 32'h0, g);
    step(1'b0, 4'b0110, 4'b0000, 4'b0000, 16'h0040, 32'h0, g);
    chk("post_reset_grant", 32'(g), 32'd1);

    // Random traffic; requests are held until accepted.
    for (int i = 0; i < NREQ; i++) new_req(i);
    for (int n = 0; n < 600; n++) begin
      logic rst;
      rst = ($urandom_range(0, 49) == 0);
      step(rst, p_v, p_we, p_lk, p_a, p_wd, g);
      for (int i = 0; i < NREQ; i++) begin
        if (i == g || !p_v[i]) new_req(i);
      end
    end

    for (int k = 0; k < 3; k++) step(1'b0, 4'b0000, 4'b0000, 4'b0000, 16'h0, 32'h0, g);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter sharing one single-port synchronous RAM among NREQ requesters. It accepts at most one read or write per cycle, drives the RAM's `we`/`addr`/`in` inputs, and routes the RAM's registered `out` back to the winning requester one cycle later, tagged with its ID. It sits between the client blocks and the RAM instance. The RAM's own reset is driven separately and is not controlled here.

## Interface
- `DATA`, default 8: data width; must match the RAM.
- `ADDR`, default 4: address width; must match the RAM.
- `NREQ`, default 4: number of requesters; minimum 2.
- `IDW`, default `$clog2(NREQ)`: width of the requester ID.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous reset, active-high.
- `req_valid`, input, NREQ: request pending, one bit per requester.
- `req_we`, input, NREQ: 1 = write, 0 = read.
- `req_lock`, input, NREQ: hold the grant after this transfer (see Configuration).
- `req_addr`, input, NREQ*ADDR: packed addresses; requester i uses slice [i*ADDR +: ADDR].
- `req_wdata`, input, NREQ*DATA: packed write data; requester i uses slice [i*DATA +: DATA].
- `req_ready`, output, NREQ: one-hot grant, or all zero.
- `rsp_valid`, output, 1: response available this cycle.
- `rsp_id`, output, IDW: ID of the requester the response belongs to.
- `rsp_rdata`, output, DATA: RAM read data, passed through combinationally.
- `ram_we`, output, 1: RAM write enable.
- `ram_addr`, output, ADDR: RAM address.
- `ram_wdata`, output, DATA: RAM write data.
- `ram_rdata`, input, DATA: RAM registered output.

## Operation
- A transfer happens on a cycle where `req_valid[i] & req_ready[i]`.
- Requesters hold `req_*` stable until accepted.
- `req_ready` is combinational from `req_valid`, the round-robin pointer and state. It never depends on the same requester's `req_we`/`req_addr`.
- **Round-robin:** search from `ptr` upward, wrapping at NREQ. The first requester with `valid` set wins.
- After a transfer by requester i, `ptr <= (i+1) mod NREQ`. With no transfer, `ptr` holds.
- **RAM drive:** `ram_we/ram_addr/ram_wdata` are combinational from the granted slice.
- With no grant, `ram_we=0`; `ram_addr`/`ram_wdata` are don't-care and held at 0.
- **Responses:** every transfer, read or write, produces exactly one response one cycle later.
- Read response: `rsp_rdata` = memory content at that address.
- Write response: `rsp_rdata` = the old content before the write (RAM read-before-write). Clients ignore it.
- **States:** ARB (normal arbitration) and LOCKED (owner only). LOCKED exists only with the macro.
- **Reset:** `state=ARB`, `ptr=0`, `owner=0`, `rsp_valid=0`, `rsp_id=0`.
- During the reset cycle, `req_ready=0` and `ram_we=0`. No transfer is taken.

## Timing
- Grant latency: 0 cycles; a request is accepted in the cycle it is presented if it wins.
- Response latency: exactly 1 cycle. `rsp_valid`/`rsp_id` are registered from the accept cycle; `rsp_rdata` is valid with them.
- Throughput: 1 transfer per cycle, back-to-back, with no bubble between different requesters.
- Same-address write at N then read at N+1: the read returns the new data.
- Reset asserted mid-operation: any response due next cycle is suppressed (`rsp_valid=0`). The RAM contents are unaffected by this block.
- Single requester continuously valid: granted every cycle.
- All NREQ valid: grants cycle in order ptr, ptr+1, and so on, so each requester is served once per NREQ cycles.

## Configuration
- `MEM_ARB_LOCK_EN` defined:
  - A transfer with `req_lock[i]=1` taken in ARB moves to LOCKED with `owner=i`.
  - In LOCKED, only `owner` may get `req_ready`, and the owner has no timeout.
  - An owner transfer with lock=1 stays in LOCKED. An owner transfer with lock=0 returns to ARB the next cycle, with `ptr=owner+1`.
  - Intended for atomic read-modify-write.
- `MEM_ARB_LOCK_EN` undefined:
  - `req_lock` is still present but ignored.
  - No LOCKED state; pure round-robin.

## Structure
- Package `mem_arb_pkg`: state enum `{ARB, LOCKED}` and an ID-width helper.
- Sub-module `mem_arb_rr_pick`: combinational picker, taking `valid` + `ptr` and producing a one-hot grant plus an encoded ID.
- Top level holds the state register, `ptr`, `owner`, the response pipeline register and the muxes.

## Test plan
- **Reset:** `reset=1`, all `req_valid=1` → `req_ready=0`, `ram_we=0`; the next cycle shows `rsp_valid=0`.
- **Write then read:**
  - Cycle 0: req0 writes 0xA5 to address 3 → `req_ready=0001`, `ram_we=1`.
  - Cycle 1: req0 reads address 3.
  - Cycle 2: `rsp_valid=1`, `rsp_id=0`, `rsp_rdata=0xA5`.
- **Fairness:** all four requesters held valid for 8 cycles, reading distinct addresses → grant IDs 0,1,2,3,0,1,2,3, and `rsp_id` follows the same sequence delayed by 1.
- **Pointer skip:** `ptr=2`, only req1 and req3 valid → req3 granted first, then req1.
- **Lock (macro on):**
  - req1 reads address 5 with lock=1, while req0/req2 are valid → only req1 is granted for the following cycles.
  - req1 writes address 5 with lock=0 → req2 is granted the next cycle.
- **Reset mid-stream:** reset asserted in the cycle after an accepted read → `rsp_valid=0` that cycle, `ptr=0`, and the next grant goes to the lowest valid ID.
